// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clock cycles
module pwm_capture #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 pwm_in,
  input  logic [CNT_WIDTH-1:0] timeout_cycles,
  output logic [CNT_WIDTH-1:0] period_cycles,
  output logic [CNT_WIDTH-1:0] high_cycles,
  output logic                 meas_valid,
  output logic                 stalled,
  output logic                 stall_level
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, high_lat_q, high_lat_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d, high_q, high_d;
  logic                   valid_q, valid_d, stalled_q, stalled_d, stall_level_q, stall_level_d;
  logic                   s, rise, fall, timeout;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign timeout = (timeout_cycles != '0) && (cnt_q >= timeout_cycles);
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_d_d         = s;
    state_d       = state_q;
    cnt_d         = cnt_q;
    high_lat_d    = high_lat_q;
    period_d      = period_q;
    high_d        = high_q;
    valid_d       = 1'b0;
    stalled_d     = stalled_q;
    stall_level_d = stall_level_q;
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      high_lat_d = '0;
      stalled_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: if (rise) begin
          state_d    = MEAS;
          cnt_d      = CNT_WIDTH'(1);
          high_lat_d = '0;
        end
        MEAS: if (rise) begin
          period_d   = cnt_q;
          high_d     = high_lat_q;
          valid_d    = 1'b1;
          stalled_d  = 1'b0;
          cnt_d      = CNT_WIDTH'(1);
          high_lat_d = '0;
        end else if (timeout) begin
          // no edge for too long: report the stuck level and wait for a fresh arming rise
          state_d       = ARM;
          stalled_d     = 1'b1;
          stall_level_d = s;
          cnt_d         = '0;
        end else begin
          high_lat_d = fall ? cnt_q : high_lat_q;
          cnt_d      = cnt_inc;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      s_d_q         <= 1'b0;
      cnt_q         <= '0;
      high_lat_q    <= '0;
      period_q      <= '0;
      high_q        <= '0;
      valid_q       <= 1'b0;
      stalled_q     <= 1'b0;
      stall_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      s_d_q         <= s_d_d;
      cnt_q         <= cnt_d;
      high_lat_q    <= high_lat_d;
      period_q      <= period_d;
      high_q        <= high_d;
      valid_q       <= valid_d;
      stalled_q     <= stalled_d;
      stall_level_q <= stall_level_d;
    end
  end
  assign period_cycles = period_q;
  assign high_cycles   = high_q;
  assign meas_valid    = valid_q;
  assign stalled       = stalled_q;
  assign stall_level   = stall_level_q;
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the PWM generator path: it recovers the period and duty counts that the generator was programmed with. Typical uses are loopback self-test of PWM outputs and measurement of external PWM or tach-style feedback signals. It sits in the PWM peripheral next to the timebase/compare logic, and its results feed the register bank.

## Interface
Parameters:
- CNT_WIDTH, 32, width of the counters, the results and the timeout register
- SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (minimum 2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; when low, the block is idle and results are held
- pwm_in  in  1  asynchronous PWM input
- timeout_cycles  in  CNT_WIDTH  maximum cycles without a rising edge before a stall is reported; 0 disables the timeout
- period_cycles  out  CNT_WIDTH  last measured period (rising edge to rising edge)
- high_cycles  out  CNT_WIDTH  last measured high time (rising edge to falling edge)
- meas_valid  out  1  one-cycle pulse; new period_cycles/high_cycles are presented in that cycle
- stalled  out  1  sticky stall flag; cleared by the next meas_valid or by disable
- stall_level  out  1  synchronized input level captured when stalled was set (0 means 0% duty, 1 means 100% duty)

One clock; reset is asynchronous and active-high.

## Operation
- Synchronizer:
  - pwm_in passes through SYNC_STAGES flops, giving `s`.
  - A further flop holds `s_d`.
  - rise = s & ~s_d; fall = ~s & s_d.
  - These flops run regardless of enable.
- State machine, state IDLE → ARM → MEAS:
  - IDLE: counter cnt = 0. Go to ARM when enable = 1.
  - ARM: wait for rise. On rise: cnt ← 1, high_lat ← 0, go to MEAS. The first rise only arms; no meas_valid is produced.
  - MEAS: cnt increments each cycle and saturates at 2^CNT_WIDTH−1.
    - On fall: high_lat ← cnt.
    - On rise: period_cycles ← cnt, high_cycles ← high_lat, meas_valid ← 1, stalled ← 0, cnt ← 1, high_lat ← 0. Stay in MEAS.
  - Any state: enable = 0 → IDLE next cycle. cnt and high_lat are cleared and stalled ← 0; period_cycles and high_cycles are held.
- Resulting values: for a waveform whose rising edges are P cycles apart and whose high time is D cycles, the block reports period_cycles = P and high_cycles = D.
- Timeout:
  - Applies in MEAS when timeout_cycles ≠ 0, cnt ≥ timeout_cycles and no rise occurs that cycle.
  - Action: stalled ← 1, stall_level ← s, go to ARM. Results are held and no meas_valid is produced.
  - In ARM, timeout is not re-evaluated.
- Priority, highest first:
  1. enable = 0
  2. rise
  3. timeout
  4. fall
  5. count

## Timing
- Reset values:
  - Outputs: period_cycles = 0, high_cycles = 0, meas_valid = 0, stalled = 0, stall_level = 0.
  - Internal: state = IDLE, cnt = 0, high_lat = 0, synchronizer and s_d = 0.
- Latency:
  - A pwm_in level first sampled at clock edge k appears on s at edge k+SYNC_STAGES−1, and rise is asserted in the cycle after that edge.
  - meas_valid, period_cycles and high_cycles are registered and are valid one cycle after rise. That is SYNC_STAGES+1 cycles after pwm_in is sampled high.
  - Because both edges see the same delay, the measured values are unaffected by it.
- meas_valid is high for exactly one cycle per measured period. Consecutive pulses are spaced by period_cycles.
- Minimum measurable waveform: period 2, high 1 (edges one cycle apart).
- Edge cases:
  - Saturation: if cnt saturates, the reported values saturate at all-ones. No wrap is permitted.
  - enable and rise in the same cycle: no meas_valid, state goes to IDLE.
  - Re-enable: requires one arming rise plus one full period before the first meas_valid.
  - If the input is high at enable, no false edge is seen, because s_d has kept tracking s.
  - rst mid-measurement: all outputs return to their reset values immediately, with no meas_valid.
  - timeout_cycles changed during MEAS: takes effect in the next cycle's compare.

## Test plan
- Locked loopback: PWM generator with period 10 and duty 3, enable = 1 → first meas_valid after the arming rise plus 10 cycles; then a pulse every 10 cycles with period_cycles = 10, high_cycles = 3.
- Minimum waveform: period 2, duty 1 → meas_valid every 2 cycles with period_cycles = 2, high_cycles = 1. Then duty changed to 0 with timeout_cycles = 8 → stalled = 1 and stall_level = 0 eight cycles after the last rise; results stay at 2/1.
- 100% duty: pwm_in held high after a valid 20/5 measurement, timeout_cycles = 50 → stalled = 1 and stall_level = 1 at cnt = 50. On resumption at period 20 / duty 5: stalled clears on the first new meas_valid, which reads 20/5.
- Disable mid-period: enable dropped at cnt = 4 of a 10/3 waveform → no meas_valid, results held, stalled = 0. On re-enable, the first pulse arrives only after arm plus 10 cycles.
- Saturation with CNT_WIDTH = 4, timeout_cycles = 0: period 20, duty 18 → period_cycles = 15, high_cycles = 15. No wrap to small values.
- Async reset asserted mid-MEAS with no clock edge pending → all outputs are 0 immediately. After release, the first meas_valid follows arm plus one full period.
